nw_control_unit: RTL and testbench

- Top-level sequencer for the Needleman-Wunsch alignment datapath.
- Accepts the symbol streams for sequences A and B and writes them into the sequence RAMs.
- On start, walks the datapath through matrix init, cell-by-cell score/direction filling and traceback.
- Reports busy/done to the board-level wrapper.
- Produces every datapath control strobe; no other block drives them.

---
 rtl/nw_pkg.sv | 19 +
 rtl/nw_seq_loader.sv | 78 +++++++
 rtl/nw_control_unit.sv | 160 ++++++++++++++++
 tb/tb_nw_control_unit.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/nw_pkg.sv
// Shared types and constants for the Needleman-Wunsch control unit.
package nw_pkg;

    typedef enum logic [3:0] {
        StIdle  = 4'd0,
        StInit  = 4'd1,
        StRd    = 4'd2,
        StCalc  = 4'd3,
        StWr    = 4'd4,
        StNext  = 4'd5,
        StTrace = 4'd6,
        StDone  = 4'd7,
        StErr   = 4'd8
    } nw_state_e;

    localparam int unsigned SymW      = 3;
    localparam int unsigned WdogLimit = 65535;

endpackage

// File: rtl/nw_seq_loader.sv
// Sequence RAM loader: per-sequence write counters, registered RAM write strobes,
// and overflow detection for beats arriving after a sequence is already full.
module nw_seq_loader
    import nw_pkg::*;
#(
    parameter int unsigned N       = 128,
    parameter int unsigned BitAddr = $clog2(N + 1)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               load_en_d_i,
    input  logic               seq_valid_i,
    input  logic               seq_sel_i,
    input  logic [SymW-1:0]    seq_sym_i,
    input  logic               seq_clear_i,
    output logic               seq_ready_o,
    output logic               en_ram_o,
    output logic               we_a_o,
    output logic               we_b_o,
    output logic [SymW-1:0]    din_ram_o,
    output logic [BitAddr:0]   addr_a_o,
    output logic [BitAddr:0]   addr_b_o,
    output logic               full_o,
    output logic               ovf_o
);

    localparam logic [BitAddr:0] AddrOne = (BitAddr + 1)'(1);
    localparam logic [BitAddr:0] AddrEnd = (BitAddr + 1)'(N + 1);

    logic [BitAddr:0] cnt_a_q, cnt_b_q, cur_cnt;
    logic             seq_ready_q, accept, wr;

    // seq_clear has priority over a beat in the same cycle.
    always_comb begin
        accept  = seq_valid_i & seq_ready_q & ~seq_clear_i;
        cur_cnt = seq_sel_i ? cnt_b_q : cnt_a_q;
        ovf_o   = accept & (cur_cnt == AddrEnd);
        wr      = accept & (cur_cnt != AddrEnd);
        full_o  = (cnt_a_q == AddrEnd) & (cnt_b_q == AddrEnd);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_a_q     <= AddrOne;
            cnt_b_q     <= AddrOne;
            seq_ready_q <= 1'b0;
            en_ram_o    <= 1'b0;
            we_a_o      <= 1'b0;
            we_b_o      <= 1'b0;
            din_ram_o   <= '0;
            addr_a_o    <= '0;
            addr_b_o    <= '0;
        end else begin
            seq_ready_q <= load_en_d_i;
            en_ram_o    <= wr;
            we_a_o      <= wr & ~seq_sel_i;
            we_b_o      <= wr & seq_sel_i;
            if (wr) begin
                din_ram_o <= seq_sym_i;
            end
            if (wr && !seq_sel_i) begin
                addr_a_o <= cnt_a_q;
                cnt_a_q  <= cnt_a_q + AddrOne;
            end
            if (wr && seq_sel_i) begin
                addr_b_o <= cnt_b_q;
                cnt_b_q  <= cnt_b_q + AddrOne;
            end
            if (seq_clear_i) begin
                cnt_a_q <= AddrOne;
                cnt_b_q <= AddrOne;
            end
        end
    end

    assign seq_ready_o = seq_ready_q;

endmodule

// File: rtl/nw_control_unit.sv
// Phase sequencer for the Needleman-Wunsch datapath; all strobes are registered.
// Optional stall watchdog enabled by defining NW_CTRL_WATCHDOG_EN.
module nw_control_unit
    import nw_pkg::*;
#(
    parameter int unsigned N       = 128,
    parameter int unsigned BitAddr = $clog2(N + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               seq_valid,
    input  logic               seq_sel,
    input  logic [SymW-1:0]    seq_sym,
    output logic               seq_ready,
    input  logic               seq_clear,
    input  logic               start,
    output logic [SymW-1:0]    din_ram,
    output logic               en_ram,
    output logic               weA,
    output logic               weB,
    output logic [BitAddr:0]   addr_dinA,
    output logic [BitAddr:0]   addr_dinB,
    output logic               en_init,
    input  logic               end_init,
    output logic               en_read,
    input  logic               calculated,
    output logic               en_ins,
    output logic               we,
    output logic               change_index,
    input  logic               end_filling,
    output logic               en_traceB,
    input  logic               end_c,
    output logic               busy,
    output logic               done,
    output logic               load_err,
    output logic [3:0]         state
);

    nw_state_e state_q, state_d;
    logic      load_err_q, load_err_d;
    logic      fill_seen_q, fill_seen_d;
    logic      load_en_d, full, ovf;
    logic      en_init_q, en_read_q, en_ins_q, we_q, change_index_q, en_traceB_q;
    logic      busy_q, done_q;

    nw_seq_loader #(
        .N       (N),
        .BitAddr (BitAddr)
    ) u_loader (
        .clk_i       (clk),
        .rst_i       (rst),
        .load_en_d_i (load_en_d),
        .seq_valid_i (seq_valid),
        .seq_sel_i   (seq_sel),
        .seq_sym_i   (seq_sym),
        .seq_clear_i (seq_clear),
        .seq_ready_o (seq_ready),
        .en_ram_o    (en_ram),
        .we_a_o      (weA),
        .we_b_o      (weB),
        .din_ram_o   (din_ram),
        .addr_a_o    (addr_dinA),
        .addr_b_o    (addr_dinB),
        .full_o      (full),
        .ovf_o       (ovf)
    );

`ifdef NW_CTRL_WATCHDOG_EN
    logic [15:0] wdog_q;

    always_ff @(posedge clk) begin
        if (rst || (state_d != state_q)) begin
            wdog_q <= '0;
        end else if (wdog_q != '1) begin
            wdog_q <= wdog_q + 16'd1;
        end
    end
`endif

    always_comb begin
        state_d     = state_q;
        load_err_d  = load_err_q;
        fill_seen_d = fill_seen_q;
        unique case (state_q)
            StIdle, StDone: begin
                if (seq_clear) begin
                    state_d = StIdle;
                end else if (start) begin
                    if (full) state_d = StInit;
                    else      load_err_d = 1'b1;
                end
            end
            StInit:  if (end_init) state_d = StRd;
            StRd: begin
                fill_seen_d = 1'b0;
                state_d     = StCalc;
            end
            StCalc:  if (calculated) state_d = StWr;
            StWr: begin
                // Remember an early end_filling so NEXT still pulses change_index.
                fill_seen_d = end_filling;
                state_d     = StNext;
            end
            StNext:  state_d = (end_filling || fill_seen_q) ? StTrace : StRd;
            StTrace: if (end_c) state_d = StDone;
            StErr:   if (seq_clear) state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if (ovf)       load_err_d = 1'b1;
        if (seq_clear) load_err_d = 1'b0;
`ifdef NW_CTRL_WATCHDOG_EN
        if ((state_q == StInit || state_q == StCalc || state_q == StTrace) &&
            (wdog_q == 16'(WdogLimit - 1))) begin
            state_d    = StErr;
            load_err_d = 1'b1;
        end
`endif
        load_en_d = (state_d == StIdle) || (state_d == StDone);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= StIdle;
            load_err_q     <= 1'b0;
            fill_seen_q    <= 1'b0;
            en_init_q      <= 1'b0;
            en_read_q      <= 1'b0;
            en_ins_q       <= 1'b0;
            we_q           <= 1'b0;
            change_index_q <= 1'b0;
            en_traceB_q    <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            load_err_q     <= load_err_d;
            fill_seen_q    <= fill_seen_d;
            en_init_q      <= (state_d == StInit);
            en_read_q      <= (state_d == StRd);
            en_ins_q       <= (state_d == StWr);
            we_q           <= (state_d == StWr);
            change_index_q <= (state_d == StNext);
            en_traceB_q    <= (state_d == StTrace);
            busy_q         <= (state_d != StIdle) && (state_d != StDone) && (state_d != StErr);
            done_q         <= (state_d == StDone);
        end
    end

    assign state        = state_q;
    assign load_err     = load_err_q;
    assign en_init      = en_init_q;
    assign en_read      = en_read_q;
    assign en_ins       = en_ins_q;
    assign we           = we_q;
    assign change_index = change_index_q;
    assign en_traceB    = en_traceB_q;
    assign busy         = busy_q;
    assign done         = done_q;

endmodule

// File: tb/tb_nw_control_unit.sv
// Directed/randomized bench for nw_control_unit with N=4 and a phase-level reference model.
module tb_nw_control_unit;

    localparam int unsigned N  = 4;
    localparam int unsigned BA = $clog2(N + 1);

    localparam logic [6:0] SNone  = 7'b0000000;
    localparam logic [6:0] SInit  = 7'b0100000;
    localparam logic [6:0] SRead  = 7'b0010000;
    localparam logic [6:0] SWr    = 7'b0001100;
    localparam logic [6:0] SNext  = 7'b0000010;
    localparam logic [6:0] STrace = 7'b0000001;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, seq_valid, seq_sel, seq_clear, start;
    logic [2:0]    seq_sym, din_ram;
    logic          seq_ready, en_ram, weA, weB;
    logic [BA:0]   addr_dinA, addr_dinB;
    logic          en_init, end_init, en_read, calculated, en_ins, we, change_index;
    logic          end_filling, en_traceB, end_c, busy, done, load_err;
    logic [3:0]    state;

    nw_control_unit #(.N(N)) dut (
        .clk(clk), .rst(rst), .seq_valid(seq_valid), .seq_sel(seq_sel), .seq_sym(seq_sym),
        .seq_ready(seq_ready), .seq_clear(seq_clear), .start(start), .din_ram(din_ram),
        .en_ram(en_ram), .weA(weA), .weB(weB), .addr_dinA(addr_dinA), .addr_dinB(addr_dinB),
        .en_init(en_init), .end_init(end_init), .en_read(en_read), .calculated(calculated),
        .en_ins(en_ins), .we(we), .change_index(change_index), .end_filling(end_filling),
        .en_traceB(en_traceB), .end_c(end_c), .busy(busy), .done(done), .load_err(load_err),
        .state(state)
    );

    int nchk = 0;
    int nfail = 0;
    int we_cnt = 0;
    int excl_err = 0;
    int exp_cnt_a, exp_cnt_b;

    always @(negedge clk) begin
        if (we) we_cnt++;
        if (($countones({en_init, en_read, en_ins, change_index, en_traceB}) > 1) ||
            (en_ram && (en_init || en_read || en_ins || change_index || en_traceB)))
            excl_err++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        nchk++;
        assert (obs === exp_v) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected control view derived from the phase number alone.
    task automatic check_ctl(input string tag, input int exp_state, input logic [6:0] exp_s);
        check({tag, "_state"}, 32'(state), 32'(exp_state));
        check({tag, "_strobes"}, 32'({en_ram, en_init, en_read, en_ins, we, change_index, en_traceB}),
              32'(exp_s));
        check({tag, "_busy"}, 32'(busy), 32'(exp_state >= 1 && exp_state <= 6));
        check({tag, "_done"}, 32'(done), 32'(exp_state == 7));
    endtask

    task automatic beat(input logic sel, input logic [2:0] sym);
        int cnt;
        cnt = sel ? exp_cnt_b : exp_cnt_a;
        seq_valid = 1'b1; seq_sel = sel; seq_sym = sym;
        tick();
        seq_valid = 1'b0;
        if (cnt <= int'(N)) begin
            check("beat_we", 32'({en_ram, weA, weB}), 32'({1'b1, ~sel, sel}));
            check("beat_din", 32'(din_ram), 32'(sym));
            check("beat_addr", 32'(sel ? addr_dinB : addr_dinA), 32'(cnt));
            if (sel) exp_cnt_b++; else exp_cnt_a++;
        end else begin
            check("ovf_drop", 32'(en_ram), 32'(0));
            check("ovf_err", 32'(load_err), 32'(1));
        end
    endtask

    task automatic full_load();
        for (int i = 0; i < int'(2 * N); i++) begin
            logic s;
            s = 1'($urandom);
            if (exp_cnt_a > int'(N)) s = 1'b1;
            if (exp_cnt_b > int'(N)) s = 1'b0;
            beat(s, 3'($urandom));
        end
    endtask

    // Entered with state == RD; leaves with state == TRACE.
    task automatic run_fill(input bit wr_end);
        for (int c = 0; c < int'(N * N); c++) begin
            int  lat;
            bit  last;
            last = (c == int'(N * N) - 1);
            tick();
            check_ctl("calc", 3, SNone);
            lat = (c == 0) ? 5 : int'($urandom_range(0, 3));
            for (int k = 0; k < lat; k++) begin
                end_c = 1'($urandom); start = 1'($urandom); end_init = 1'($urandom);
                tick();
                check_ctl("calc_wait", 3, SNone);
            end
            end_c = 1'b0; start = 1'b0; end_init = 1'b0;
            calculated = 1'b1;
            tick();
            calculated = 1'b0;
            check_ctl("wr", 4, SWr);
            end_filling = last && wr_end;
            tick();
            end_filling = 1'b0;
            check_ctl("next", 5, SNext);
            if (last) begin
                end_filling = !wr_end;
                tick();
                end_filling = 1'b0;
                check_ctl("trace_entry", 6, STrace);
            end else begin
                tick();
                check_ctl("rd", 2, SRead);
            end
        end
    endtask

    initial begin
        rst = 1'b1; seq_valid = 1'b0; seq_sel = 1'b0; seq_sym = 3'd0; seq_clear = 1'b0;
        start = 1'b0; end_init = 1'b0; calculated = 1'b0; end_filling = 1'b0; end_c = 1'b0;
        exp_cnt_a = 1; exp_cnt_b = 1;
        tick(); tick();
        check_ctl("reset", 0, SNone);
        check("reset_ready", 32'(seq_ready), 32'(0));
        check("reset_err", 32'(load_err), 32'(0));
        rst = 1'b0;
        tick();
        check("idle_ready", 32'(seq_ready), 32'(1));

        // Short load then refused start.
        for (int i = 0; i < 3; i++) beat(1'b0, 3'($urandom));
        start = 1'b1; tick(); start = 1'b0;
        check("short_start_err", 32'(load_err), 32'(1));
        check_ctl("short_start", 0, SNone);

        // seq_clear beats a concurrent beat.
        seq_clear = 1'b1; seq_valid = 1'b1; seq_sel = 1'b0;
        tick();
        seq_clear = 1'b0; seq_valid = 1'b0;
        exp_cnt_a = 1; exp_cnt_b = 1;
        check("clear_no_write", 32'(en_ram), 32'(0));
        check("clear_err", 32'(load_err), 32'(0));

        full_load();
        beat(1'b0, 3'($urandom));
        beat(1'b1, 3'($urandom));

        start = 1'b1; tick(); start = 1'b0;
        check_ctl("start", 1, SInit);
        check("start_ready", 32'(seq_ready), 32'(0));
        seq_valid = 1'b1; tick(); seq_valid = 1'b0;
        check_ctl("init_beat_ignored", 1, SInit);
        repeat ($urandom_range(0, 3)) begin
            tick();
            check_ctl("init_hold", 1, SInit);
        end
        end_init = 1'b1; tick(); end_init = 1'b0;
        check_ctl("rd0", 2, SRead);

        we_cnt = 0;
        run_fill(1'b0);
        check("we_count", 32'(we_cnt), 32'(N * N));
        for (int k = 0; k < 8; k++) begin
            tick();
            check_ctl("trace", 6, STrace);
        end
        end_c = 1'b1; tick(); end_c = 1'b0;
        check_ctl("done", 7, SNone);
        check("done_ready", 32'(seq_ready), 32'(1));
        tick();
        check_ctl("done_hold", 7, SNone);

        // Re-align retained data; end_filling arrives in WR this time.
        start = 1'b1; tick(); start = 1'b0;
        check_ctl("restart", 1, SInit);
        end_init = 1'b1; tick(); end_init = 1'b0;
        check_ctl("rd1", 2, SRead);
        we_cnt = 0;
        run_fill(1'b1);
        check("we_count2", 32'(we_cnt), 32'(N * N));
        end_c = 1'b1; tick(); end_c = 1'b0;
        check_ctl("done2", 7, SNone);

        // Reset in CALC.
        start = 1'b1; tick(); start = 1'b0;
        end_init = 1'b1; tick(); end_init = 1'b0;
        tick();
        check_ctl("calc3", 3, SNone);
        rst = 1'b1; tick();
        check_ctl("rst_mid", 0, SNone);
        check("rst_mid_ready", 32'(seq_ready), 32'(0));
        rst = 1'b0; tick();
        exp_cnt_a = 1; exp_cnt_b = 1;
        start = 1'b1; tick(); start = 1'b0;
        check("post_rst_start_err", 32'(load_err), 32'(1));
        check_ctl("post_rst_start", 0, SNone);
        beat(1'b0, 3'($urandom));

`ifdef NW_CTRL_WATCHDOG_EN
        seq_clear = 1'b1; tick(); seq_clear = 1'b0;
        exp_cnt_a = 1; exp_cnt_b = 1;
        full_load();
        start = 1'b1; tick(); start = 1'b0;
        end_init = 1'b1; tick(); end_init = 1'b0;
        tick();
        check_ctl("wd_calc", 3, SNone);
        repeat (65534) tick();
        check_ctl("wd_last", 3, SNone);
        tick();
        check_ctl("wd_err", 8, SNone);
        check("wd_err_flag", 32'(load_err), 32'(1));
        seq_clear = 1'b1; tick(); seq_clear = 1'b0;
        check_ctl("wd_clear", 0, SNone);
`endif

        check("exclusivity", 32'(excl_err), 32'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule
